seg7_scan_driver: RTL and testbench

- Multiplexed hex display driver for an N-digit common-anode 7-segment display; the downstream consumer of the 500 Hz debug scan clock.
- Samples the slow scan square wave as data in the fast `clk` domain and turns each transition into a digit-advance tick.
- Steps through the digits with an anti-ghosting blank gap.
- Latches the displayed value once per frame, so a digit never shows a mix of old and new value.

---
 rtl/seg7_pkg.sv | 17 +
 rtl/seg7_scan_driver_hex.sv | 13 +
 rtl/seg7_scan_driver.sv | 148 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the 7-segment scan driver.
//   state_t  - scan FSM states
//   SEG_OFF  - all cathodes off (active-low)
//   HEX_SEG  - hex nibble to {g,f,e,d,c,b,a} active-low pattern, indexed by nibble
package seg7_pkg;

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entry 15 first, entry 0 last.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_scan_driver_hex.sv
// hex_to_seg7: combinational hex nibble to active-low 7-segment decoder.
//   nib - 4-bit hex digit
//   seg - cathodes {g,f,e,d,c,b,a}, active-low
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed hex driver for an N-digit common-anode display.
// Each edge of the slow scan wave advances one digit; every digit is preceded
// by an all-anodes-off gap, and the displayed value is snapshotted per frame.
//   clk, rst     - system clock, async active-high reset
//   clk_500      - scan square wave, sampled as async data
//   value        - nibble k shown on digit k (digit 0 rightmost)
//   dp_in        - per-digit decimal point, 1 = lit
//   blank_in     - per-digit force-off, 1 = dark
//   an           - anodes, active-low, at most one low
//   seg, dp      - cathodes, active-low
//   frame_tick   - one-cycle pulse when a new snapshot is latched
// Optional macro SEG7_LZ_BLANK_EN: leading-zero suppression on the snapshot.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int BLANK_CYCLES = 1000,
  parameter int IDX_W        = $clog2(N_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_500,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_tick
);

  localparam int CNT_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic s1, s2, s3, tick;
  state_t                state;
  logic [IDX_W-1:0]      idx, idx_inc;
  logic [CNT_W-1:0]      cnt;
  logic [4*N_DIGITS-1:0] snap_value;
  logic [N_DIGITS-1:0]   snap_dp, snap_blank, new_blank;
  logic [3:0]            nib_sel;
  logic [6:0]            seg_dec, seg_nxt;
  logic [N_DIGITS-1:0]   an_nxt;
  logic                  dp_nxt;

  // Two-flop synchronizer plus history flop; either edge of the wave is a tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= clk_500;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick    = s2 ^ s3;
  assign idx_inc = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);

`ifdef SEG7_LZ_BLANK_EN
  // Digit k is suppressed when it and every nibble above it are zero.
  // Digit 0 is never suppressed so a zero value still shows "0".
  logic [N_DIGITS-1:0] lz_mask;
  logic                hi_zero;
  always_comb begin
    lz_mask = '0;
    hi_zero = 1'b1;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      hi_zero    = hi_zero & (value[4*k +: 4] == 4'h0);
      lz_mask[k] = hi_zero;
    end
  end
  assign new_blank = blank_in | lz_mask;
`else
  assign new_blank = blank_in;
`endif

  assign nib_sel = snap_value[{idx, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .nib (nib_sel),
    .seg (seg_dec)
  );

  always_comb begin
    an_nxt  = '1;
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b1;
    if (state == DRIVE && !snap_blank[idx]) begin
      an_nxt[idx] = 1'b0;
      seg_nxt     = seg_dec;
      dp_nxt      = ~snap_dp[idx];
    end
  end

  // Outputs are registered from the current state, so they trail it by a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      snap_value <= '0;
      snap_dp    <= '0;
      snap_blank <= '0;
      frame_tick <= 1'b0;
      an         <= '1;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
    end else begin
      an         <= an_nxt;
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      frame_tick <= 1'b0;
      case (state)
        IDLE: if (tick) begin
          idx        <= '0;
          snap_value <= value;
          snap_dp    <= dp_in;
          snap_blank <= new_blank;
          frame_tick <= 1'b1;
          cnt        <= CNT_LOAD;
          state      <= BLANK;
        end
        // Ticks seen here are intentionally dropped.
        BLANK: begin
          if (cnt == '0) state <= DRIVE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        DRIVE: if (tick) begin
          idx <= idx_inc;
          if (idx_inc == '0) begin
            snap_value <= value;
            snap_dp    <= dp_in;
            snap_blank <= new_blank;
            frame_tick <= 1'b1;
          end
          cnt   <= CNT_LOAD;
          state <= BLANK;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed bench for seg7_scan_driver.
// Two instances share all inputs: BLANK_CYCLES = 10 and BLANK_CYCLES = 0.
module tb_seg7_scan_driver;

  localparam int N        = 4;
  localparam int BLK      = 10;
  localparam int TICK_MIN = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clk_500 = 1'b0;
  logic [15:0]   value = 16'h0000;
  logic [N-1:0]  dp_in = '0;
  logic [N-1:0]  blank_in = '0;
  logic [N-1:0]  an10, an0;
  logic [6:0]    seg10, seg0;
  logic          dp10, dp0, ft10, ft0;

  int n_run  = 0;
  int n_fail = 0;
  bit chk0   = 1'b1;

  always #5 clk = ~clk;

  seg7_scan_driver #(.N_DIGITS(N), .BLANK_CYCLES(BLK)) dut (
    .clk(clk), .rst(rst), .clk_500(clk_500), .value(value), .dp_in(dp_in),
    .blank_in(blank_in), .an(an10), .seg(seg10), .dp(dp10), .frame_tick(ft10)
  );

  seg7_scan_driver #(.N_DIGITS(N), .BLANK_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .clk_500(clk_500), .value(value), .dp_in(dp_in),
    .blank_in(blank_in), .an(an0), .seg(seg0), .dp(dp0), .frame_tick(ft0)
  );

  initial assert (BLK < TICK_MIN) else $fatal(1, "BLANK_CYCLES too large for bench tick spacing");

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One scan edge, then check gap, frame_tick and the lit digit.
  // Relative to the edge: tick acts at posedge 3, 0-gap DUT lights at 5,
  // 10-gap DUT is dark from 4 through 14 and lights at 15.
  task automatic digit(input logic [3:0] ean, input logic [6:0] eseg,
                       input logic edp, input logic eft);
    clk_500 = ~clk_500;
    step(3);
    check("frame_tick", ft10, eft);
    if (chk0) check("frame_tick0", ft0, eft);
    step(1);
    check("ft_pulse", ft10, 0);
    check("gap_start", an10, 4'hF);
    step(1);
    if (chk0) begin
      check("an0", an0, ean);
      check("seg0", seg0, eseg);
    end
    step(9);
    check("gap_end", an10, 4'hF);
    step(1);
    check("an", an10, ean);
    check("seg", seg10, eseg);
    check("dp", dp10, edp);
  endtask

  initial begin
    step(2);
    check("rst_an", an10, 4'hF);
    check("rst_seg", seg10, 7'h7F);
    check("rst_dp", dp10, 1);
    check("rst_ft", ft10, 0);
    check("rst_an0", an0, 4'hF);
    rst = 1'b0;
    step(5);
    check("idle_dark", an10, 4'hF);

    // Scan order
    value = 16'h12AF;
    digit(4'b1110, 7'h0E, 1, 1);
    digit(4'b1101, 7'h08, 1, 0);
    digit(4'b1011, 7'h24, 1, 0);
    digit(4'b0111, 7'h79, 1, 0);

    // Mid-frame change stays hidden until the next frame
    digit(4'b1110, 7'h0E, 1, 1);
    digit(4'b1101, 7'h08, 1, 0);
    value = 16'hFFFF;
    digit(4'b1011, 7'h24, 1, 0);
    digit(4'b0111, 7'h79, 1, 0);
    digit(4'b1110, 7'h0E, 1, 1);
    digit(4'b1101, 7'h0E, 1, 0);
    digit(4'b1011, 7'h0E, 1, 0);
    digit(4'b0111, 7'h0E, 1, 0);

    // Masks
    blank_in = 4'b1000;
    dp_in    = 4'b0001;
    digit(4'b1110, 7'h0E, 0, 1);
    digit(4'b1101, 7'h0E, 1, 0);
    digit(4'b1011, 7'h0E, 1, 0);
    digit(4'b1111, 7'h7F, 1, 0);

    // Async reset mid-DRIVE, between clock edges
    digit(4'b1110, 7'h0E, 0, 1);
    #2 rst = 1'b1;
    clk_500 = 1'b0;
    #1;
    check("arst_an", an10, 4'hF);
    check("arst_seg", seg10, 7'h7F);
    check("arst_dp", dp10, 1);
    step(1);
    rst = 1'b0;
    step(20);
    check("post_rst_dark", an10, 4'hF);
    digit(4'b1110, 7'h0E, 0, 1);

    // Edge injected 3 cycles into BLANK is dropped
    chk0 = 1'b0;
    clk_500 = ~clk_500;
    step(6);
    clk_500 = ~clk_500;
    step(9);
    check("drop_an", an10, 4'b1101);
    step(20);
    check("drop_hold", an10, 4'b1101);
    digit(4'b1011, 7'h0E, 1, 0);
    digit(4'b1111, 7'h7F, 1, 0);

`ifdef SEG7_LZ_BLANK_EN
    value    = 16'h0034;
    blank_in = '0;
    dp_in    = '0;
    digit(4'b1110, 7'h19, 1, 1);
    digit(4'b1101, 7'h30, 1, 0);
    digit(4'b1111, 7'h7F, 1, 0);
    digit(4'b1111, 7'h7F, 1, 0);
    value = 16'h0000;
    digit(4'b1110, 7'h40, 1, 1);
    digit(4'b1111, 7'h7F, 1, 0);
    digit(4'b1111, 7'h7F, 1, 0);
    digit(4'b1111, 7'h7F, 1, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
